ha_stream_master: RTL and testbench

//  Stream master/checker for the other end of the halfAdder valid/ready interface.

---
 rtl/ha_stream_master.sv | 177 +++++++++++++++++
 tb/tb_ha_stream_master.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ha_stream_master.sv
// Traffic source and scoreboard for a valid/ready half adder: drives operand pairs,
// queues the expected {carry,sum} per accepted pair and checks the returned results.
module ha_stream_master #(
    parameter int NUM_TXN   = 16,
    parameter int CNT_W     = 8,
    parameter int MAX_OUTST = 4,
    parameter int ERR_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       stall_mask,
    output logic             a_out,
    output logic             b_out,
    output logic             valid_out,
    input  logic             ready_in,
    input  logic             sum_in,
    input  logic             carry_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             mismatch,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam logic [CNT_W-1:0] NUM   = CNT_W'(NUM_TXN);
    localparam logic [PTR_W:0]   DEPTH = (PTR_W + 1)'(MAX_OUTST);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   fifo_cnt_q, fifo_cnt_d;
    logic [1:0]       fifo_q [MAX_OUTST];
    logic [1:0]       fifo_d [MAX_OUTST];
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic             mismatch_q, mismatch_d;
    logic             valid_out_q, valid_out_d;
    logic             a_q, a_d, b_q, b_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [1:0]       phase_q, phase_d;

    logic tx_hs, rx_hs, fifo_nempty, pop, rx_err;

    // ready_out follows the throttle pattern live so stalls land on the intended phase.
    assign ready_out   = (state_q == S_RUN) & ~stall_mask[phase_q];
    assign tx_hs       = valid_out_q & ready_in;
    assign rx_hs       = valid_in & ready_out;
    assign fifo_nempty = (fifo_cnt_q != '0);
    assign pop         = rx_hs & fifo_nempty;
    assign rx_err      = rx_hs & (~fifo_nempty | ({carry_in, sum_in} != fifo_q[rd_ptr_q]));

    always_comb begin
        state_d     = state_q;
        tx_cnt_d    = tx_cnt_q;
        rx_cnt_d    = rx_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fifo_cnt_d  = fifo_cnt_q;
        fifo_d      = fifo_q;
        err_cnt_d   = err_cnt_q;
        mismatch_d  = 1'b0;
        valid_out_d = valid_out_q;
        a_d         = a_q;
        b_d         = b_q;
        phase_d     = phase_q + 2'd1;

        case (state_q)
            S_RUN: begin
                if (tx_hs) begin
                    fifo_d[wr_ptr_q] = {a_q & b_q, a_q ^ b_q};
                    wr_ptr_d         = wr_ptr_q + 1'b1;
                    tx_cnt_d         = tx_cnt_q + 1'b1;
                end
                if (pop) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
                if (tx_hs && !pop)
                    fifo_cnt_d = fifo_cnt_q + 1'b1;
                else if (pop && !tx_hs)
                    fifo_cnt_d = fifo_cnt_q - 1'b1;
                if (rx_err) begin
                    mismatch_d = 1'b1;
                    if (err_cnt_q != '1)
                        err_cnt_d = err_cnt_q + 1'b1;
                end
                // A pending offer is frozen until accepted; otherwise look ahead
                // at post-handshake counts so back-to-back offers are possible.
                if (!(valid_out_q && !ready_in)) begin
                    valid_out_d = (tx_cnt_d < NUM) && (fifo_cnt_d < DEPTH);
                    a_d         = tx_cnt_d[1];
                    b_d         = tx_cnt_d[0];
                end
                if (tx_cnt_q == NUM && rx_cnt_q == NUM) begin
                    state_d     = S_DONE;
                    valid_out_d = 1'b0;
                end
            end
            default: begin
                valid_out_d = 1'b0;
                if (start) begin
                    state_d     = S_RUN;
                    tx_cnt_d    = '0;
                    rx_cnt_d    = '0;
                    wr_ptr_d    = '0;
                    rd_ptr_d    = '0;
                    fifo_cnt_d  = '0;
                    err_cnt_d   = '0;
                    valid_out_d = 1'b1;
                    a_d         = 1'b0;
                    b_d         = 1'b0;
                end
            end
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
        pass_d = done_d && (err_cnt_d == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            tx_cnt_q    <= '0;
            rx_cnt_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
            for (int i = 0; i < MAX_OUTST; i++) fifo_q[i] <= '0;
            err_cnt_q   <= '0;
            mismatch_q  <= 1'b0;
            valid_out_q <= 1'b0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            phase_q     <= '0;
        end else begin
            state_q     <= state_d;
            tx_cnt_q    <= tx_cnt_d;
            rx_cnt_q    <= rx_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
            fifo_q      <= fifo_d;
            err_cnt_q   <= err_cnt_d;
            mismatch_q  <= mismatch_d;
            valid_out_q <= valid_out_d;
            a_q         <= a_d;
            b_q         <= b_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            phase_q     <= phase_d;
        end
    end

    assign a_out     = a_q;
    assign b_out     = b_q;
    assign valid_out = valid_out_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign mismatch  = mismatch_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_ha_stream_master.sv
// Directed bench for ha_stream_master with a one-deep behavioural half adder on the far end.
module tb_ha_stream_master;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [3:0] stall_mask = 4'b0000;
    logic       a_out, b_out, valid_out, ready_in, sum_in, carry_in, valid_in, ready_out;
    logic       busy, done, pass, mismatch;
    logic [7:0] err_cnt;

    // adder model controls
    logic no_ret = 1'b0, corrupt = 1'b0, force_v = 1'b0, rnd_mode = 1'b0, rnd_bit = 1'b1;
    logic res_v, res_sum, res_carry;
    int   mdl_idx;

    // monitor state
    int   tx_hs, op_err, mm_cnt, hold_viol;
    logic prev_hold;
    logic [1:0] prev_ab, exp_ab;

    int tests = 0;
    int fails = 0;

    ha_stream_master dut (
        .clk(clk), .rst(rst), .start(start), .stall_mask(stall_mask),
        .a_out(a_out), .b_out(b_out), .valid_out(valid_out), .ready_in(ready_in),
        .sum_in(sum_in), .carry_in(carry_in), .valid_in(valid_in), .ready_out(ready_out),
        .busy(busy), .done(done), .pass(pass), .mismatch(mismatch), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    assign ready_in = (rnd_mode ? rnd_bit : 1'b1) & (~res_v | ready_out | no_ret);
    assign valid_in = (res_v & ~no_ret) | force_v;
    assign sum_in   = res_sum;
    assign carry_in = res_carry;

    always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_v <= 1'b0; res_sum <= 1'b0; res_carry <= 1'b0; mdl_idx <= 0;
        end else if (start && !busy) begin
            mdl_idx <= 0;
        end else if (valid_out && ready_in) begin
            res_v     <= 1'b1;
            res_sum   <= (a_out ^ b_out) ^ (corrupt && mdl_idx == 3);
            res_carry <= a_out & b_out;
            mdl_idx   <= mdl_idx + 1;
        end else if (valid_in && ready_out) begin
            res_v <= 1'b0;
        end
    end

    assign exp_ab = tx_hs[1:0];

    always @(negedge clk) begin
        if (!rst || (start && !busy)) begin
            tx_hs  <= 0;
            mm_cnt <= 0;
        end else begin
            if (mismatch) mm_cnt <= mm_cnt + 1;
            if (prev_hold && !(valid_out && {a_out, b_out} == prev_ab)) hold_viol <= hold_viol + 1;
            if (valid_out && ready_in) begin
                if ({a_out, b_out} != exp_ab) op_err <= op_err + 1;
                tx_hs <= tx_hs + 1;
            end
        end
        prev_hold <= rst && valid_out && !ready_in;
        prev_ab   <= {a_out, b_out};
    end

    initial begin
        op_err = 0; hold_viol = 0; prev_hold = 1'b0; prev_ab = 2'b00;
    end

    task automatic tick;
        @(posedge clk); #2;
    endtask

    task automatic smp;
        @(negedge clk); #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag, input int max);
        for (int i = 0; i < max; i++) begin
            smp;
            if (done) break;
        end
        chk(tag, 32'(done), 32'd1);
    endtask

    task automatic wait_tx(input string tag, input int n, input int max);
        for (int i = 0; i < max; i++) begin
            smp;
            if (tx_hs >= n) break;
        end
        chk(tag, 32'(tx_hs >= n), 32'd1);
    endtask

    task automatic run_start;
        tick; start = 1'b1;
        tick; start = 1'b0;
    endtask

    function automatic logic [31:0] all_outs();
        return {16'h0, a_out, b_out, valid_out, ready_out, busy, done, pass, mismatch, err_cnt};
    endfunction

    initial begin
        repeat (3) smp;
        chk("reset_outputs", all_outs(), 32'h0);
        tick; rst = 1'b1;
        smp;
        chk("idle_busy", 32'(busy), 32'd0);

        // ideal adder, no stalls
        run_start;
        smp;
        chk("t1_first_valid", 32'(valid_out), 32'd1);
        chk("t1_first_ab", 32'({a_out, b_out}), 32'd0);
        chk("t1_busy", 32'(busy), 32'd1);
        wait_done("t1_done", 200);
        chk("t1_pass", 32'(pass), 32'd1);
        chk("t1_err", 32'(err_cnt), 32'd0);
        chk("t1_tx_count", 32'(tx_hs), 32'd16);
        chk("t1_operands", 32'(op_err), 32'd0);
        chk("t1_mismatch", 32'(mm_cnt), 32'd0);
        chk("t1_idle_chan", 32'({busy, valid_out, ready_out}), 32'd0);

        // random ready_in with ready_out throttle
        tick; stall_mask = 4'b1010; rnd_mode = 1'b1; start = 1'b1;
        tick; start = 1'b0;
        wait_done("t2_done", 800);
        chk("t2_pass", 32'(pass), 32'd1);
        chk("t2_tx_count", 32'(tx_hs), 32'd16);
        chk("t2_hold_stable", 32'(hold_viol), 32'd0);
        chk("t2_operands", 32'(op_err), 32'd0);
        tick; stall_mask = 4'b0000; rnd_mode = 1'b0;

        // wrong sum on txn 3 (a=1,b=1)
        corrupt = 1'b1;
        run_start;
        wait_done("t4_done", 200);
        chk("t4_mismatch_pulses", 32'(mm_cnt), 32'd1);
        chk("t4_err", 32'(err_cnt), 32'd1);
        chk("t4_pass", 32'(pass), 32'd0);
        corrupt = 1'b0;
        repeat (3) smp;
        chk("t4_err_hold", 32'(err_cnt), 32'd1);

        // unexpected result while FIFO empty
        tick; start = 1'b1; force_v = 1'b1;
        tick; start = 1'b0;
        smp;
        chk("t5_err_cleared", 32'(err_cnt), 32'd0);
        chk("t5_pass_cleared", 32'(pass), 32'd0);
        tick; force_v = 1'b0;
        smp;
        chk("t5_mismatch_pulse", 32'(mismatch), 32'd1);
        chk("t5_err_one", 32'(err_cnt), 32'd1);
        wait_done("t5_done", 200);
        chk("t5_err_final", 32'(err_cnt), 32'd1);
        chk("t5_pass", 32'(pass), 32'd0);
        chk("t5_tx_count", 32'(tx_hs), 32'd16);

        // results never come back: FIFO fills and TX stops
        tick; no_ret = 1'b1;
        run_start;
        repeat (30) smp;
        chk("t3_tx_count", 32'(tx_hs), 32'd4);
        chk("t3_valid_low", 32'(valid_out), 32'd0);
        chk("t3_busy_done", 32'({busy, done}), 32'b10);
        run_start;
        repeat (5) smp;
        chk("t3_start_ignored", 32'({busy, tx_hs[7:0]}), 32'h104);

        // reset recovery and mid-run abort
        tick; rst = 1'b0; no_ret = 1'b0;
        smp;
        chk("t6_reset_stuck", all_outs(), 32'h0);
        tick; rst = 1'b1;
        run_start;
        wait_tx("t6_reach5", 5, 100);
        tick; rst = 1'b0;
        smp;
        chk("t6_reset_midrun", all_outs(), 32'h0);
        repeat (2) tick;
        rst = 1'b1;
        run_start;
        wait_done("t6_done", 200);
        chk("t6_pass", 32'(pass), 32'd1);
        chk("t6_tx_count", 32'(tx_hs), 32'd16);
        chk("t6_err", 32'(err_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
